// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the RV32IM pipeline hazard controller: forwarding selects,
// mul/div sequencer states and the EX-operand forwarding priority function.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN  = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // x0 is never a real producer, so a zero destination never forwards.
    function automatic fwd_sel_t fwd_pick(
        input logic [4:0] src,
        input logic       rw_m,
        input logic [4:0] wr_m,
        input logic       rw_w,
        input logic [4:0] wr_w
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (rw_m && (wr_m != 5'd0) && (wr_m == src)) begin
            sel = FWD_MEM;
        end else if (rw_w && (wr_w != 5'd0) && (wr_w == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/md_stall_seq.sv
// Multi-cycle mul/div sequencer: pulses MDStart and holds the pipeline front
// for MD_LAT-1 cycles while the op sits in EX.
module md_stall_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LAT = 34
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic MDOpE,
    output logic stall,
    output logic MDStart,
    output logic MDBusy
);

    localparam int  CNT_W = ($clog2(MD_LAT) < 1) ? 1 : $clog2(MD_LAT);
    localparam bit  MULTI = (MD_LAT > 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULTI ? (MD_LAT - 2) : 0);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The start cycle already counts as one stall cycle, hence the load of MD_LAT-2.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        MDStart = 1'b0;
        case (state_q)
            RUN: begin
                if (MDOpE) begin
                    MDStart = 1'b1;
                    if (MULTI) begin
                        stall   = 1'b1;
                        cnt_d   = CNT_LOAD;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (!RST_N) begin
            stall   = 1'b0;
            MDStart = 1'b0;
        end
    end

    assign MDBusy = stall;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32IM pipeline: EX forwarding selects,
// load-use stall, branch flush and mul/div hold, merged by priority.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LAT = 34
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic [4:0] WriteRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       PCSrcE,
    input  logic       MDOpE,
    output logic       EN_F,
    output logic       EN_D,
    output logic       CLR_D,
    output logic       EN_E,
    output logic       CLR_E,
    output logic       CLR_M,
    output logic       MDStart,
    output logic       MDBusy,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE
);

    logic     md_stall;
    logic     lduse;
    fwd_sel_t fwd_a, fwd_b;

    md_stall_seq #(
        .MD_LAT (MD_LAT)
    ) u_md_seq (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .MDOpE   (MDOpE),
        .stall   (md_stall),
        .MDStart (MDStart),
        .MDBusy  (MDBusy)
    );

    assign fwd_a = fwd_pick(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
    assign fwd_b = fwd_pick(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);

    assign ForwardAE = RST_N ? fwd_a : FWD_RF;
    assign ForwardBE = RST_N ? fwd_b : FWD_RF;

    assign lduse = MemtoRegE & RegWriteE & (WriteRegE != 5'd0) &
                   ((WriteRegE == RsD) | (WriteRegE == RtD));

    // Mul/div hold beats branch flush, which beats load-use; reset beats all.
    always_comb begin
        EN_F  = 1'b1;
        EN_D  = 1'b1;
        EN_E  = 1'b1;
        CLR_D = 1'b0;
        CLR_E = 1'b0;
        CLR_M = 1'b0;
        if (!RST_N) begin
            EN_F = 1'b1;
        end else if (md_stall) begin
            EN_F  = 1'b0;
            EN_D  = 1'b0;
            EN_E  = 1'b0;
            CLR_M = 1'b1;
        end else if (PCSrcE) begin
            CLR_D = 1'b1;
            CLR_E = 1'b1;
        end else if (lduse) begin
            EN_F  = 1'b0;
            EN_D  = 1'b0;
            CLR_E = 1'b1;
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage RV32IM pipeline. It drives the enable and clear inputs of the PC register and the IF_ID, ID_EX and EX_MEM pipeline registers. It also produces the EX-stage forwarding selects. It sequences multi-cycle M-extension operations by holding the front of the pipeline and injecting bubbles into MEM until the operation's fixed latency has elapsed.

## Interface
- MD_LAT, 34: cycles an M-ext op occupies EX (legal 1..64).
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- RsD, RtD  in  5  source registers of the instruction in DECODE.
- RsE, RtE  in  5  source registers of the instruction in EXECUTE.
- WriteRegE, WriteRegM, WriteRegW  in  5  destination registers in EX, MEM and WB.
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables in EX, MEM and WB.
- MemtoRegE  in  1  the instruction in EX is a load.
- PCSrcE  in  1  taken branch or jump resolved in EX.
- MDOpE  in  1  the instruction in EX is a multi-cycle mul/div.
- EN_F  out  1  PC register enable (0 = hold).
- EN_D  out  1  IF_ID enable (0 = hold).
- CLR_D  out  1  IF_ID clear.
- EN_E  out  1  ID_EX enable (0 = hold).
- CLR_E  out  1  ID_EX clear (bubble).
- CLR_M  out  1  EX_MEM clear (bubble).
- MDStart  out  1  one-cycle start pulse to the mul/div unit.
- MDBusy  out  1  a mul/div op is in progress.
- ForwardAE, ForwardBE  out  2  EX operand select: 00 register file, 01 WB result, 10 MEM ALUOut.

## Operation
- Forwarding is combinational.
  - ForwardAE = 10 if RegWriteM, WriteRegM != 0 and WriteRegM == RsE.
  - Otherwise ForwardAE = 01 if RegWriteW, WriteRegW != 0 and WriteRegW == RsE.
  - Otherwise ForwardAE = 00.
  - ForwardBE follows the same rule with RtE. MEM has priority over WB.
- Load-use hazard: lduse = MemtoRegE & RegWriteE & (WriteRegE != 0) & (WriteRegE == RsD | WriteRegE == RtD).
  - Response: EN_F = 0, EN_D = 0, CLR_E = 1.
- Branch flush: when PCSrcE = 1, CLR_D = 1 and CLR_E = 1. Enables stay 1.
- Mul/div FSM, states RUN and BUSY, with down-counter cnt of width $clog2(MD_LAT) (minimum 1).
  - RUN with MDOpE = 1 and MD_LAT > 1:
    - Assert EN_F = EN_D = EN_E = 0 and CLR_M = 1.
    - Assert MDStart and MDBusy.
    - Load cnt <= MD_LAT-2 and go to BUSY.
  - BUSY with cnt != 0: keep the same holds and CLR_M, assert MDBusy, decrement cnt.
  - BUSY with cnt == 0: release all holds, CLR_M = 0, MDBusy = 0, go to RUN. The op advances to MEM on this edge.
  - MD_LAT = 1: the FSM never leaves RUN. MDStart still pulses, and no stall occurs.
- Priority, highest first:
  1. Reset.
  2. Mul/div stall: overrides lduse and PCSrcE, and CLR_D = CLR_E = 0 while it is active.
  3. Branch flush: overrides lduse. Enables stay 1, CLR_D = CLR_E = 1.
  4. Load-use stall.
- PCSrcE and MDOpE are never both 1. The bench asserts this.

## Timing
- Reset state: RUN, cnt = 0.
- Output values while RST_N = 0:
  - EN_F = EN_D = EN_E = 1.
  - CLR_D = CLR_E = CLR_M = 0.
  - MDStart = MDBusy = 0.
  - ForwardAE = ForwardBE = 00.
- Reset asserted during BUSY drops the stall immediately (asynchronously). The next op restarts from RUN.
- All outputs are combinational from the inputs and the FSM state, so they take effect at the next CLK edge. No output is registered.
- Mul/div timing:
  - Stall length is MD_LAT-1 cycles.
  - The op occupies EX for MD_LAT cycles.
  - MDStart is high only in the first EX cycle.
- Load-use costs exactly one bubble. On the next cycle the load is in MEM, lduse is 0, and forwarding selects 01 once the load reaches WB.
- Inputs from ID_EX are frozen while in BUSY. The FSM ignores MDOpE in BUSY.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - fwd_sel_t enum: FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - md_state_t enum: RUN, BUSY.
- Sub-module md_stall_seq contains the FSM and counter. Its ports are CLK, RST_N, MDOpE, stall, MDStart and MDBusy.
- The top level adds the forwarding and hazard comparators and the priority merge.

## Test plan
- Forwarding: RsE = 5, WriteRegM = 5, RegWriteM = 1, WriteRegW = 5, RegWriteW = 1 -> ForwardAE = 10. Dropping RegWriteM -> 01. WriteRegM = 0 with RegWriteM = 1 -> never 10.
- Load-use: MemtoRegE = 1, RegWriteE = 1, WriteRegE = 7, RtD = 7 -> EN_F = EN_D = 0 and CLR_E = 1 for exactly 1 cycle, then all enables return to 1.
- Branch: PCSrcE = 1 for 1 cycle -> CLR_D = CLR_E = 1 in that cycle only. With lduse active at the same time, EN_F and EN_D stay 1.
- Mul/div with MD_LAT = 4: MDOpE = 1 -> MDStart for 1 cycle, then EN_F/EN_D/EN_E = 0, CLR_M = 1 and MDBusy = 1 for 3 cycles, release on the 4th cycle. Repeat with MD_LAT = 1 (no stall) and MD_LAT = 2 (1-cycle stall).
- Mul/div over load-use: lduse conditions applied during BUSY -> CLR_E stays 0 and ID_EX is held.
- Reset mid-op: RST_N low in the 2nd BUSY cycle -> all enables 1 immediately. After release, the state is RUN and a new MDOpE restarts the full MD_LAT-1 stall.
